// File: rtl/dmem_io_pkg.sv
// Shared definitions for the data-memory / MMIO bridge.
// Holds the MMIO select bit, register indices, UART state encoding and the
// UART status word layout, so software-test generators can reuse them.
package dmem_io_pkg;

    localparam int unsigned MMIO_BIT  = 31;
    localparam int unsigned REG_IDX_W = 3;

    localparam logic [REG_IDX_W-1:0] IDX_LED         = 3'd0;
    localparam logic [REG_IDX_W-1:0] IDX_TIMER       = 3'd1;
    localparam logic [REG_IDX_W-1:0] IDX_UART_TX     = 3'd2;
    localparam logic [REG_IDX_W-1:0] IDX_UART_STATUS = 3'd3;
    localparam logic [REG_IDX_W-1:0] IDX_SWITCH      = 3'd4;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // Status word low byte: count[7:4], busy[3], overflow[2], empty[1], full[0]
    typedef struct packed {
        logic [3:0] count;
        logic       busy;
        logic       overflow;
        logic       empty;
        logic       full;
    } uart_status_t;

    // FIFO occupancy clipped to the 4-bit status field
    function automatic logic [3:0] sat_count4(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/dmem_io_bridge_uart_tx_fifo.sv
// TX FIFO plus 8N1 serializer.
// Ports: clock/reset; push + push_data enqueue a byte; clear_overflow clears
// the sticky drop flag; full/empty/count/overflow/busy report state; tx is the
// serial line (idle high).
module uart_tx_fifo
    import dmem_io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             clear_overflow,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             busy,
    output logic             tx
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    uart_state_e   state, state_d;
    logic [CW-1:0] clk_cnt, clk_cnt_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shreg, shreg_d;
    logic          tx_d;
    logic          pop, push_ok, bit_done;
    logic [CNT_W-1:0] count_d;
    logic          overflow_d;

    assign bit_done = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    // A push into a full FIFO still fits when the head leaves in the same cycle
    assign push_ok  = push & (~full | pop);

    // Serializer next-state; tx is registered so the line never glitches
    always_comb begin
        state_d   = state;
        clk_cnt_d = clk_cnt;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        tx_d      = tx;
        pop       = 1'b0;
        unique case (state)
            UART_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shreg_d   = mem[rd_ptr];
                    clk_cnt_d = '0;
                    state_d   = UART_START;
                    tx_d      = 1'b0;
                end
            end
            UART_START: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = UART_DATA;
                    tx_d      = shreg[0];
                end else begin
                    clk_cnt_d = clk_cnt + CW'(1);
                end
            end
            UART_DATA: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        shreg_d   = {1'b0, shreg[7:1]};
                        tx_d      = shreg[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt + CW'(1);
                end
            end
            UART_STOP: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    // Chain straight into the next start bit when data is waiting
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = mem[rd_ptr];
                        state_d = UART_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = UART_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt + CW'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    // FIFO occupancy and sticky overflow; a dropped push beats a clear
    always_comb begin
        count_d = count;
        unique case ({push_ok, pop})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
        overflow_d = (overflow & ~clear_overflow) | (push & ~push_ok);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= UART_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_d;
            clk_cnt  <= clk_cnt_d;
            bit_idx  <= bit_idx_d;
            shreg    <= shreg_d;
            tx       <= tx_d;
            busy     <= (state_d != UART_IDLE);
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            count    <= count_d;
            empty    <= (count_d == '0);
            full     <= (count_d == CNT_W'(FIFO_DEPTH));
            overflow <= overflow_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dmem_io_bridge.sv
// Bridge between the processor data-memory port and the data RAM, with an
// MMIO window (LEDs, cycle timer, UART TX + status, synchronized switches).
// Ports: clock/reset; address_dmem/data/wren from the M stage; q_dmem load
// data (combinational); ram_* to the data RAM; switches in, leds and uart_tx out.
module dmem_io_bridge
    import dmem_io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [11:0] ram_address,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q,
    input  logic [15:0] switches,
    output logic [15:0] leds,
    output logic        uart_tx
);

    logic                 mmio_sel;
    logic [REG_IDX_W-1:0] idx;
    logic                 wr_led, wr_timer, wr_tx, wr_status;
    logic [31:0]          timer;
    logic [15:0]          sw_meta, sw_sync;
    logic                 fifo_full, fifo_empty, fifo_overflow, uart_busy;
    logic [CNT_W-1:0]     fifo_count;
    uart_status_t         status;
    logic                 unused_addr;

    assign mmio_sel    = address_dmem[MMIO_BIT];
    assign idx         = address_dmem[REG_IDX_W-1:0];
    assign unused_addr = ^address_dmem[30:12];

    // RAM passthrough; MMIO stores are masked off the RAM
    assign ram_address = address_dmem[11:0];
    assign ram_data    = data;
    assign ram_wren    = wren & ~mmio_sel;

    assign wr_led    = wren & mmio_sel & (idx == IDX_LED);
    assign wr_timer  = wren & mmio_sel & (idx == IDX_TIMER);
    assign wr_tx     = wren & mmio_sel & (idx == IDX_UART_TX);
    assign wr_status = wren & mmio_sel & (idx == IDX_UART_STATUS);

    // LED register, cycle timer (clear beats increment), switch synchronizer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            leds    <= '0;
            timer   <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            if (wr_led) leds <= data[15:0];
            timer   <= wr_timer ? 32'd0 : timer + 32'd1;
            sw_meta <= switches;
            sw_sync <= sw_meta;
        end
    end

    uart_tx_fifo #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CNT_W        (CNT_W)
    ) u_uart_tx_fifo (
        .clock          (clock),
        .reset          (reset),
        .push           (wr_tx),
        .push_data      (data[7:0]),
        .clear_overflow (wr_status),
        .full           (fifo_full),
        .empty          (fifo_empty),
        .count          (fifo_count),
        .overflow       (fifo_overflow),
        .busy           (uart_busy),
        .tx             (uart_tx)
    );

    assign status.count    = sat_count4(32'(fifo_count));
    assign status.busy     = uart_busy;
    assign status.overflow = fifo_overflow;
    assign status.empty    = fifo_empty;
    assign status.full     = fifo_full;

    // Load mux: same-cycle, MMIO reads never look at ram_q
    always_comb begin
        q_dmem = 32'd0;
        if (!mmio_sel) begin
            q_dmem = ram_q;
        end else begin
            unique case (idx)
                IDX_LED:         q_dmem = {16'd0, leds};
                IDX_TIMER:       q_dmem = timer;
                IDX_UART_STATUS: q_dmem = {24'd0, status};
                IDX_SWITCH:      q_dmem = {16'd0, sw_sync};
                default:         q_dmem = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Self-checking bench for dmem_io_bridge with a fast UART (4 clocks per bit).
// Bytes written to UART_TX that the FIFO should accept are queued; a line
// monitor decodes each 8N1 frame and compares it against the queue head.
module tb_dmem_io_bridge;

    localparam int CPB = 4;
    localparam logic [31:0] A_LED    = 32'h8000_0000;
    localparam logic [31:0] A_TIMER  = 32'h8000_0001;
    localparam logic [31:0] A_TX     = 32'h8000_0002;
    localparam logic [31:0] A_STATUS = 32'h8000_0003;
    localparam logic [31:0] A_SWITCH = 32'h8000_0004;
    localparam logic [31:0] A_UNMAP  = 32'h8000_0006;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dmem, data, ram_q, q_dmem, ram_data;
    logic        wren, ram_wren, uart_tx;
    logic [11:0] ram_address;
    logic [15:0] switches, leds;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    dmem_io_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .CNT_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .switches     (switches),
        .leds         (leds),
        .uart_tx      (uart_tx)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Store committed at the next rising edge; returns just after that edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        @(posedge clock);
        #1;
        wren = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        address_dmem = a;
        wren         = 1'b0;
        #1;
        check_eq(tag, q_dmem, exp);
    endtask

    // Line monitor: sample mid-bit on falling clock edges
    logic       prev_tx = 1'b1;
    logic       mon_busy = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'd0;

    always @(negedge clock) begin
        if (reset) begin
            mon_busy <= 1'b0;
        end else if (!mon_busy) begin
            if (prev_tx && !uart_tx) begin
                mon_busy <= 1'b1;
                mon_cnt  <= 0;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt == 2) begin
                check_eq("uart_start_bit", 32'(uart_tx), 32'd0);
            end else if (mon_cnt == 2 + 9 * CPB) begin
                check_eq("uart_stop_bit", 32'(uart_tx), 32'd1);
                if (exp_q.size() == 0)
                    check_eq("uart_frame_expected", 32'(exp_q.size()), 32'd1);
                else
                    check_eq("uart_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                mon_busy <= 1'b0;
            end else if (mon_cnt >= 2 + CPB && ((mon_cnt - 2) % CPB) == 0) begin
                mon_byte[(mon_cnt - 2 - CPB) / CPB] <= uart_tx;
            end
        end
        prev_tx <= uart_tx;
    end

    logic [41:0] tx_seen, tx_exp;
    logic [9:0]  frame;
    int          busy_cycles;
    int          budget;

    initial begin
        reset        = 1'b1;
        address_dmem = 32'd0;
        data         = 32'd0;
        wren         = 1'b0;
        ram_q        = 32'd0;
        switches     = 16'h0000;
        #12;
        check_eq("reset_uart_tx", 32'(uart_tx), 32'd1);
        check_eq("reset_leds", 32'(leds), 32'd0);
        bus_read("reset_status", A_STATUS, 32'h0000_0002);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // RAM passthrough
        address_dmem = 32'h0000_0010;
        data         = 32'hDEAD_BEEF;
        wren         = 1'b1;
        ram_q        = 32'h1234_5678;
        #1;
        check_eq("ram_wren_store", 32'(ram_wren), 32'd1);
        check_eq("ram_address", 32'(ram_address), 32'h010);
        check_eq("ram_data", ram_data, 32'hDEAD_BEEF);
        wren = 1'b0;
        #1;
        check_eq("ram_load", q_dmem, 32'h1234_5678);
        address_dmem = A_LED;
        data         = 32'h0000_A5A5;
        wren         = 1'b1;
        #1;
        check_eq("ram_wren_mmio", 32'(ram_wren), 32'd0);
        check_eq("mmio_ignores_ram_q", q_dmem, 32'd0);
        @(posedge clock);
        #1;
        wren = 1'b0;
        check_eq("leds_port", 32'(leds), 32'h0000_A5A5);
        bus_read("led_read", A_LED, 32'h0000_A5A5);

        // Timer clear, read back one cycle after the clearing cycle
        bus_write(A_TIMER, 32'h0);
        address_dmem = A_TIMER;
        @(posedge clock);
        #1;
        check_eq("timer_after_clear", q_dmem, 32'd1);

        // Switch synchronizer and unmapped index
        switches = 16'h1234;
        bus_read("switch_lat0", A_SWITCH, 32'd0);
        @(posedge clock);
        #1;
        check_eq("switch_lat1", q_dmem, 32'd0);
        @(posedge clock);
        #1;
        check_eq("switch_lat2", q_dmem, 32'h0000_1234);
        bus_write(A_UNMAP, 32'hFFFF_FFFF);
        bus_read("unmapped_read", A_UNMAP, 32'd0);

        // Single frame 0x55: per-cycle line shape and busy duration
        exp_q.push_back(8'h55);
        bus_write(A_TX, 32'h0000_0055);
        address_dmem = A_STATUS;
        frame = {1'b1, 8'h55, 1'b0};
        tx_exp[0]  = 1'b1;
        tx_exp[41] = 1'b1;
        for (int i = 1; i <= 40; i++) tx_exp[i] = frame[(i - 1) / CPB];
        busy_cycles = 0;
        for (int i = 0; i < 42; i++) begin
            @(negedge clock);
            tx_seen[i] = uart_tx;
            if (q_dmem[3]) busy_cycles++;
        end
        check_eq("frame_shape_lo", tx_seen[31:0], tx_exp[31:0]);
        check_eq("frame_shape_hi", 32'(tx_seen[41:32]), 32'(tx_exp[41:32]));
        check_eq("busy_cycles", 32'(busy_cycles), 32'd40);

        // Ten back-to-back pushes: one popped, eight queued, one dropped
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_q.push_back(8'(8'hA0 + i));
            bus_write(A_TX, 32'(8'hA0 + i));
        end
        bus_read("status_full_ovf", A_STATUS, 32'h0000_008D);
        bus_write(A_STATUS, 32'h0);
        bus_read("status_ovf_clear", A_STATUS, 32'h0000_0089);
        budget = 0;
        while (exp_q.size() != 0 && budget < 12 * 10 * CPB) begin
            @(posedge clock);
            budget++;
        end
        check_eq("fifo_drained", 32'(exp_q.size()), 32'd0);
        repeat (5) @(posedge clock);
        #1;
        bus_read("status_idle", A_STATUS, 32'h0000_0002);

        // Timer wrap
        address_dmem = A_TIMER;
        dut.timer = 32'hFFFF_FFFF;
        #1;
        check_eq("timer_preload", q_dmem, 32'hFFFF_FFFF);
        @(posedge clock);
        #1;
        check_eq("timer_wrap", q_dmem, 32'd0);

        // Asynchronous reset in the middle of a data bit
        exp_q.push_back(8'h3C);
        bus_write(A_TX, 32'h0000_003C);
        repeat (15) @(posedge clock);
        #2;
        check_eq("midframe_busy", 32'(dut.u_uart_tx_fifo.busy), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_eq("reset_tx_immediate", 32'(uart_tx), 32'd1);
        bus_read("reset_status_mid", A_STATUS, 32'h0000_0002);
        bus_read("reset_timer", A_TIMER, 32'd0);
        check_eq("reset_leds_mid", 32'(leds), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_eq("timer_restart", q_dmem, 32'd1);
        repeat (12 * CPB) @(posedge clock);
        #1;
        bus_read("status_after_reset", A_STATUS, 32'h0000_0002);
        check_eq("no_leftover_frames", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_io_bridge.md
# dmem_io_bridge

Memory-mapped I/O bridge between the pipelined processor's data-memory port and the data RAM. Decodes each data address, forwards normal loads/stores to the RAM, and serves a small MMIO register window: LEDs, a free-running cycle timer, a synchronized switch input, and an 8N1 UART transmitter with a TX FIFO. It is invisible to software that only touches RAM: no added latency and no stalls.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥ 2
- CNT_W, 4, FIFO count width; must equal log2(FIFO_DEPTH)+1

Ports:
- clock  in  1  single system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- address_dmem  in  32  word address from processor M stage
- data  in  32  store data from processor
- wren  in  1  store enable from processor
- q_dmem  out  32  load data to processor
- ram_address  out  12  word address to data RAM
- ram_data  out  32  write data to RAM
- ram_wren  out  1  RAM write enable
- ram_q  in  32  RAM read data
- switches  in  16  asynchronous board switches
- leds  out  16  LED register
- uart_tx  out  1  serial output, idle high

## Operation
- Decode: address_dmem[31]=0 selects RAM; =1 selects MMIO, register index = address_dmem[2:0].
- RAM path: ram_address = address_dmem[11:0]; ram_data = data; ram_wren = wren & ~address_dmem[31]. q_dmem = ram_q when RAM is selected.
- MMIO map (index: read / write):
  - 0 LED: {16'b0, leds} / leds <= data[15:0]
  - 1 TIMER: 32-bit cycle counter / any write clears it to 0
  - 2 UART_TX: 0 / push data[7:0] into FIFO
  - 3 UART_STATUS: {24'b0, count[CNT_W-1:0] at [7:4] (saturate to 4 bits), busy[3], overflow[2], empty[1], full[0]} / any write clears overflow
  - 4 SWITCH: {16'b0, switches after 2-flop synchronizer} / ignored
  - 5–7: read 0 / write ignored
- MMIO writes never reach the RAM; MMIO reads never depend on ram_q.
- Timer: increments by 1 every cycle, wraps 0xFFFFFFFF→0; a clearing write makes the next value 0 (the clear wins over the increment).
- FIFO push: accepted if not full, or if full with a pop in the same cycle. Otherwise the byte is dropped and overflow sets (sticky). If a clear-overflow write and a dropped push coincide, overflow ends at 1.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - busy = state≠IDLE.
- Reset (async, any time including mid-frame): leds=0, timer=0, FIFO empty, overflow=0, synchronizer flops=0, FSM=IDLE, uart_tx=1 immediately. An in-flight frame is abandoned.

## Timing
- q_dmem is combinational from address_dmem / ram_q / register state, valid in the same cycle as the address. The value reflects register state before that cycle's posedge.
- Stores: register effects are visible to a load in the following cycle (e.g. a timer write is read back as 0 or 1 depending on spacing; the bench reads back in the next cycle and expects 1).
- Switch read latency: 2 cycles from the input change to the value being visible.
- FIFO to line: the byte written at edge N appears in the FIFO at N. The pop happens at N+1 if IDLE, and the start bit is driven from N+1.
- Frame length: exactly 10·CLKS_PER_BIT cycles. Back-to-back frames have no extra idle cycles between STOP and the next START.

## Structure
- Shared package dmem_io_pkg holds the MMIO base bit, register indices, UART state encoding, and the status bit positions, for reuse by software-test generators.
- One sub-module: uart_tx_fifo (FIFO plus the UART serializer FSM, with push/full/empty/count/busy outputs). Decode, timer, LED, and synchronizer stay in the top module.

## Test plan
- RAM passthrough: store 0xDEADBEEF to address 0x00000010 → ram_wren=1 and ram_address=0x010. A load from 0x10 returns the ram_q value. A store to 0x80000000 → ram_wren=0.
- LED/timer: write 0x0000A5A5 to 0x80000000 → leds=0xA5A5. Write to 0x80000001, read it the next cycle → 1. Preload 0xFFFFFFFF → reads 0 one cycle later.
- UART frame (CLKS_PER_BIT=4): write 0x55 to 0x80000002 → uart_tx shows 0,1,0,1,0,1,0,1,0,1, 4 cycles each, then idle 1. busy=1 for 40 cycles.
- FIFO full/overflow (FIFO_DEPTH=8): 10 writes in consecutive cycles → the first is popped, 8 are queued, 1 is dropped. Status reads full=1, overflow=1. Writing 0x80000003 clears overflow. All 9 accepted bytes are transmitted in order.
- Switch sync: switches 0x0000→0x1234 → SWITCH reads 0 for 2 cycles, then 0x1234. An unmapped index 6 reads 0.
- Reset mid-frame: assert reset during DATA → uart_tx=1 in the same cycle, status reads empty=1, busy=0, and the timer restarts at 0.
